// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring-subtract step per cycle, then a sign-fix cycle.
module md_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
   logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, is_div_q, is_div_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + (2*WIDTH)'(1);
   endfunction

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic               is_signed);
      return (is_signed && v < 0) ? neg_w(v) : v;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      is_div_d = is_div_q;

      mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, a_q} : '0);
      div_shift = {rem_q, quo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      prod      = {rem_q, quo_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = magnitude(rs_data, op[0]);
               b_d      = magnitude(rt_data, op[0]);
               neg_a_d  = op[0] & rs_data[WIDTH-1];
               neg_b_d  = op[0] & rt_data[WIDTH-1];
               is_div_d = op[1];
               rem_d    = '0;
               // multiplier shifts out of quo for MUL, dividend shifts out of quo for DIV
               quo_d    = op[1] ? magnitude(rs_data, op[0]) : magnitude(rt_data, op[0]);
               cnt_d    = '0;
               state_d  = CALC;
            end else begin
               if (hi_we) hi_d = rs_data;
               if (lo_we) lo_d = rs_data;
            end
         end
         CALC: begin
            if (is_div_q) begin
               rem_d = div_ge ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], div_ge};
            end else begin
               rem_d = mul_sum[WIDTH:1];
               quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            if (!is_div_q) begin
               if (neg_a_q ^ neg_b_q) prod = neg_2w(prod);
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else if (b_q == '0) begin
               lo_d = '1;
               hi_d = neg_a_q ? neg_w(a_q) : a_q;
            end else begin
               lo_d = (neg_a_q ^ neg_b_q) ? neg_w(quo_q) : quo_q;
               hi_d = neg_a_q ? neg_w(rem_q) : rem_q;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Working registers are fully rewritten on every launch, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      is_div_q <= is_div_d;
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: scoreboard queue of expected {hi,lo}, one task per scenario.
module tb_md_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, hi_we, lo_we;
   logic [1:0]   op;
   logic [W-1:0] rs_data, rt_data;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [63:0]  exp_q[$];

   always #5 clk = ~clk;

   md_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'd0: p = {32'd0, a} * {32'd0, b};
         2'd1: p = 64'(sa * sb);
         2'd2: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e);
      @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0; op = ~o; rs_data = $urandom; rt_data = $urandom;
   endtask

   task automatic wait_done(output int k, output int bc);
      k = 0; bc = 0;
      while (done !== 1'b1 && k < 200) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'd0; rs_data = '0; rt_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({busy, done} !== 2'b00) begin
         n_fail++; $display("FAIL reset_ctrl: busy/done=%b required 00", {busy, done});
      end
      n_tests++;
      if ({hi, lo} !== 64'd0) begin
         n_fail++; $display("FAIL reset_hilo: got %h required 0", {hi, lo});
      end
   endtask

   task automatic test_multu();
      int k, bc;
      logic [63:0] e;
      launch(2'd0, 32'h1234_5678, 32'h8765_4321, 64'h09A0_CD05_70B8_8D78);
      wait_done(k, bc);
      e = exp_q.pop_front();
      n_tests++;
      if (k != W + 1) begin
         n_fail++; $display("FAIL multu_latency: done after %0d edges required %0d", k, W + 1);
      end
      n_tests++;
      if ({hi, lo} !== e) begin
         n_fail++; $display("FAIL multu_result: got %h required %h", {hi, lo}, e);
      end
   endtask

   task automatic test_signed_div();
      logic [1:0]  ops [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
      logic [31:0] as  [4] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
      logic [31:0] bs  [4] = '{32'd5, 32'd7, 32'd2, 32'hFFFF_FFFF};
      logic [63:0] es  [4] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0002_0000_000E,
                               64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000};
      int k, bc;
      logic [63:0] e;
      for (int i = 0; i < 4; i++) begin
         launch(ops[i], as[i], bs[i], es[i]);
         wait_done(k, bc);
         e = exp_q.pop_front();
         n_tests++;
         if ({hi, lo} !== e) begin
            n_fail++; $display("FAIL signed_div_%0d: got %h required %h", i, {hi, lo}, e);
         end
      end
   endtask

   task automatic test_div_zero();
      int k, bc;
      logic [63:0] e;
      launch(2'd2, 32'h55, 32'd0, 64'h0000_0055_FFFF_FFFF);
      wait_done(k, bc);
      e = exp_q.pop_front();
      n_tests++;
      if ({hi, lo} !== e) begin
         n_fail++; $display("FAIL divu_zero: got %h required %h", {hi, lo}, e);
      end
      n_tests++;
      if (bc != W + 1) begin
         n_fail++; $display("FAIL divu_zero_busy: busy %0d cycles required %0d", bc, W + 1);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL done_pulse: done=%b required 0", done);
      end
      launch(2'd3, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF);
      wait_done(k, bc);
      e = exp_q.pop_front();
      n_tests++;
      if ({hi, lo} !== e) begin
         n_fail++; $display("FAIL div_zero_neg: got %h required %h", {hi, lo}, e);
      end
   endtask

   task automatic test_busy_ignore();
      int k, bc, extra;
      logic [63:0] e;
      launch(2'd0, 32'd3, 32'd7, model(2'd0, 32'd3, 32'd7));
      repeat (5) @(negedge clk);
      start = 1'b1; op = 2'd2; rs_data = 32'd1000; rt_data = 32'd9;
      @(negedge clk);
      start = 1'b0;
      wait_done(k, bc);
      e = exp_q.pop_front();
      n_tests++;
      if ({hi, lo} !== e) begin
         n_fail++; $display("FAIL busy_ignore_result: got %h required %h", {hi, lo}, e);
      end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_tests++;
      if (extra != 0) begin
         n_fail++; $display("FAIL busy_ignore_queue: %0d busy/done cycles required 0", extra);
      end
   endtask

   task automatic test_reset_midop();
      int extra;
      logic [63:0] e;
      launch(2'd1, 32'hF00D_1234, 32'h0BAD_CAFE, model(2'd1, 32'hF00D_1234, 32'h0BAD_CAFE));
      e = exp_q.pop_front();
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL midop_reset_busy: busy=%b required 0", busy);
      end
      n_tests++;
      if ({hi, lo} !== 64'd0) begin
         n_fail++; $display("FAIL midop_reset_hilo: got %h required 0 (aborted %h)", {hi, lo}, e);
      end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      n_tests++;
      if (extra != 0) begin
         n_fail++; $display("FAIL midop_reset_done: %0d done pulses required 0", extra);
      end
   endtask

   task automatic test_mthi_mtlo();
      int k, bc;
      logic [63:0] e;
      @(negedge clk); hi_we = 1'b1; rs_data = 32'hDEAD_BEEF;
      @(negedge clk); hi_we = 1'b0;
      n_tests++;
      if (hi !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL mthi: got %h required DEADBEEF", hi);
      end
      lo_we = 1'b1; rs_data = 32'hCAFE_F00D;
      @(negedge clk); lo_we = 1'b0;
      n_tests++;
      if ({hi, lo} !== 64'hDEAD_BEEF_CAFE_F00D) begin
         n_fail++; $display("FAIL mtlo: got %h required DEADBEEFCAFEF00D", {hi, lo});
      end
      hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'h0BAD_F00D;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
      n_tests++;
      if ({hi, lo} !== 64'h0BAD_F00D_0BAD_F00D) begin
         n_fail++; $display("FAIL mthi_mtlo_both: got %h required 0BADF00D0BADF00D", {hi, lo});
      end
      start = 1'b1; hi_we = 1'b1; op = 2'd0; rs_data = 32'h1111_1111; rt_data = 32'd3;
      exp_q.push_back(model(2'd0, 32'h1111_1111, 32'd3));
      @(negedge clk); start = 1'b0; hi_we = 1'b0;
      n_tests++;
      if ({hi, lo} !== 64'h0BAD_F00D_0BAD_F00D) begin
         n_fail++; $display("FAIL mthi_with_start: got %h required 0BADF00D0BADF00D", {hi, lo});
      end
      repeat (3) @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'h2222_2222;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
      n_tests++;
      if ({hi, lo} !== 64'h0BAD_F00D_0BAD_F00D) begin
         n_fail++; $display("FAIL mthi_while_busy: got %h required 0BADF00D0BADF00D", {hi, lo});
      end
      wait_done(k, bc);
      e = exp_q.pop_front();
      n_tests++;
      if ({hi, lo} !== e) begin
         n_fail++; $display("FAIL mthi_then_result: got %h required %h", {hi, lo}, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] edge_vals [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF};
      logic [31:0] a, b;
      logic [1:0]  o;
      int k, bc;
      logic [63:0] e;
      for (int i = 0; i < 12; i++) begin
         o = 2'($urandom_range(0, 3));
         a = (i % 3 == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
         b = (i % 4 == 1) ? edge_vals[$urandom_range(0, 3)] : $urandom;
         if (i % 2 == 0) b = b >> $urandom_range(0, 28);
         launch(o, a, b, model(o, a, b));
         wait_done(k, bc);
         e = exp_q.pop_front();
         n_tests++;
         if ({hi, lo} !== e) begin
            n_fail++;
            $display("FAIL b2b_%0d op=%0d a=%h b=%h: got %h required %h", i, o, a, b, {hi, lo}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_signed_div();
      test_div_zero();
      test_busy_ignore();
      test_reset_midop();
      test_mthi_mtlo();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
